ni_injection_arbiter: RTL and testbench

//   Shares the single network-injection port of the single-unit network interface among NUM_PORTS local flit sources.
//   - Round-robin arbitration with wormhole packet lock: the owner holds the port from head flit to tail flit.
//   - Credit-based flow control towards the attached router input buffer.
//   - Sits between the unit-side packetizers and the NI-to-router link.
//

---
 rtl/ni_injection_arbiter.sv | 147 ++++++++++++++
 tb/tb_ni_injection_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_injection_arbiter.sv
// Round-robin, packet-locked arbiter feeding the NI-to-router injection link with credit flow control.
// Optional statistics counters are enabled by defining NI_INJ_ARB_STATS_EN.
//
// state  | meaning
// IDLE   | no owner; pick the next head-flit requester at or after rr_ptr
// LOCKED | owner holds the link from head flit until its tail flit is accepted
module ni_injection_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int FLIT_WIDTH = 64,
   parameter int CREDITS    = 4,
   parameter int CNT_WIDTH  = $clog2(CREDITS + 1)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NUM_PORTS-1:0]            in_valid_i,
   input  logic [NUM_PORTS*FLIT_WIDTH-1:0] in_flit_i,
   input  logic [NUM_PORTS-1:0]            in_head_i,
   input  logic [NUM_PORTS-1:0]            in_tail_i,
   output logic [NUM_PORTS-1:0]            in_ready_o,
   output logic                            out_valid_o,
   output logic [FLIT_WIDTH-1:0]           out_flit_o,
   output logic                            out_tail_o,
   input  logic                            credit_i,
   output logic [NUM_PORTS-1:0]            grant_o,
   output logic [CNT_WIDTH-1:0]            credits_o,
   output logic                            credit_err_o
`ifdef NI_INJ_ARB_STATS_EN
   ,
   output logic [31:0]                     pkt_count_o,
   output logic [31:0]                     stall_cycles_o
`endif
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [CNT_WIDTH-1:0] CREDITS_MAX = CNT_WIDTH'(CREDITS);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                state;
   logic [PTR_W-1:0]      rr_ptr;
   logic [PTR_W-1:0]      owner;
   logic [CNT_WIDTH-1:0]  credits;
   logic                  credit_err;

   logic                  arb_found;
   logic [PTR_W-1:0]      arb_idx;
   logic [PTR_W-1:0]      cand;
   logic                  xfer;
   logic [FLIT_WIDTH-1:0] owner_flit;
   logic                  owner_tail;
   logic [PTR_W-1:0]      owner_next;

   // first head-flit requester at or after rr_ptr, wrapping around
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = PTR_W'((int'(rr_ptr) + i) % NUM_PORTS);
         if (!arb_found && in_valid_i[cand] && in_head_i[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   assign in_ready_o  = (state == LOCKED && credits != '0) ? grant_o : '0;
   assign xfer        = |(in_valid_i & in_ready_o);
   assign owner_flit  = in_flit_i[int'(owner)*FLIT_WIDTH +: FLIT_WIDTH];
   assign owner_tail  = in_tail_i[owner];
   assign owner_next  = (owner == PTR_W'(NUM_PORTS - 1)) ? '0 : owner + 1'b1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         grant_o     <= '0;
         owner       <= '0;
         rr_ptr      <= '0;
         out_valid_o <= 1'b0;
         out_flit_o  <= '0;
         out_tail_o  <= 1'b0;
      end else begin
         out_valid_o <= xfer;
         if (xfer) begin
            out_flit_o <= owner_flit;
            out_tail_o <= owner_tail;
         end
         case (state)
            IDLE: begin
               if (arb_found) begin
                  state   <= LOCKED;
                  owner   <= arb_idx;
                  grant_o <= NUM_PORTS'(1) << arb_idx;
               end
            end
            LOCKED: begin
               if (xfer && owner_tail) begin
                  state   <= IDLE;
                  grant_o <= '0;
                  rr_ptr  <= owner_next;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // a return and a send in the same cycle cancel out
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         credits    <= CREDITS_MAX;
         credit_err <= 1'b0;
      end else begin
         case ({credit_i, xfer})
            2'b10: begin
               if (credits == CREDITS_MAX) credit_err <= 1'b1;
               else                        credits    <= credits + 1'b1;
            end
            2'b01:   credits <= credits - 1'b1;
            default: credits <= credits;
         endcase
      end
   end

   assign credits_o    = credits;
   assign credit_err_o = credit_err;

`ifdef NI_INJ_ARB_STATS_EN
   logic [31:0] pkt_count;
   logic [31:0] stall_cycles;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pkt_count    <= '0;
         stall_cycles <= '0;
      end else begin
         if (xfer && owner_tail) pkt_count <= pkt_count + 32'd1;
         if (state == LOCKED && in_valid_i[owner] && credits == '0 && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
      end
   end

   assign pkt_count_o    = pkt_count;
   assign stall_cycles_o = stall_cycles;
`endif

endmodule

// File: tb/tb_ni_injection_arbiter.sv
// Scoreboard bench for ni_injection_arbiter: directed packets per port, expected flits queued
// up front and checked by an independent output monitor.
module tb_ni_injection_arbiter;

   localparam int NP = 4;
   localparam int FW = 64;
   localparam int CW = 3;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic [NP-1:0]   in_valid_i = '0;
   logic [NP*FW-1:0] in_flit_i = '0;
   logic [NP-1:0]   in_head_i = '0;
   logic [NP-1:0]   in_tail_i = '0;
   logic [NP-1:0]   in_ready_o;
   logic            out_valid_o;
   logic [FW-1:0]   out_flit_o;
   logic            out_tail_o;
   logic            credit_i = 1'b0;
   logic [NP-1:0]   grant_o;
   logic [CW-1:0]   credits_o;
   logic            credit_err_o;
`ifdef NI_INJ_ARB_STATS_EN
   logic [31:0]     pkt_count_o;
   logic [31:0]     stall_cycles_o;
`endif

   ni_injection_arbiter #(.NUM_PORTS(NP), .FLIT_WIDTH(FW), .CREDITS(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .in_valid_i(in_valid_i), .in_flit_i(in_flit_i), .in_head_i(in_head_i), .in_tail_i(in_tail_i),
      .in_ready_o(in_ready_o),
      .out_valid_o(out_valid_o), .out_flit_o(out_flit_o), .out_tail_o(out_tail_o),
      .credit_i(credit_i), .grant_o(grant_o), .credits_o(credits_o), .credit_err_o(credit_err_o)
`ifdef NI_INJ_ARB_STATS_EN
      , .pkt_count_o(pkt_count_o), .stall_cycles_o(stall_cycles_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {logic [63:0] flit; logic head; logic tail;} src_t;
   typedef struct packed {logic [63:0] flit; logic tail;} exp_t;

   src_t  src_q [NP][$];
   exp_t  exp_q [$];
   int    pulse_q [$];
   logic [NP-1:0] acc = '0;
   logic  loop_en = 1'b0;
   logic  ov_d1 = 1'b0, ov_d2 = 1'b0;
   int    checks = 0, passes = 0;
   int    n_out = 0, mcyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // output monitor / scoreboard
   always @(negedge clk_i) begin
      exp_t e;
      mcyc++;
      if (!rst_i && out_valid_o) begin
         n_out++;
         pulse_q.push_back(mcyc);
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_flit: got %0h expected none", out_flit_o);
         end else begin
            e = exp_q.pop_front();
            chk("out_flit", out_flit_o, e.flit);
            chk("out_tail", {63'd0, out_tail_o}, {63'd0, e.tail});
         end
      end
   end

   task automatic tick_cr(input logic cr);
      @(negedge clk_i);
      for (int p = 0; p < NP; p++)
         if (acc[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
      credit_i = cr | (loop_en & ov_d2);
      ov_d2 = ov_d1;
      ov_d1 = out_valid_o;
      for (int p = 0; p < NP; p++) begin
         if (src_q[p].size() > 0) begin
            in_valid_i[p]          = 1'b1;
            in_flit_i[p*FW +: FW]  = src_q[p][0].flit;
            in_head_i[p]           = src_q[p][0].head;
            in_tail_i[p]           = src_q[p][0].tail;
         end else begin
            in_valid_i[p] = 1'b0;
            in_head_i[p]  = 1'b0;
            in_tail_i[p]  = 1'b0;
         end
         acc[p] = in_valid_i[p] & in_ready_o[p];
      end
   endtask

   task automatic tick();
      tick_cr(1'b0);
   endtask

   task automatic send(input int p, input int n, input logic [63:0] base, input bit push_exp);
      src_t s;
      exp_t e;
      for (int i = 0; i < n; i++) begin
         s.flit = base + 64'(i);
         s.head = (i == 0);
         s.tail = (i == n - 1);
         src_q[p].push_back(s);
         if (push_exp) begin
            e.flit = s.flit;
            e.tail = s.tail;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic push_exp1(input logic [63:0] f, input logic t);
      exp_t e;
      e.flit = f;
      e.tail = t;
      exp_q.push_back(e);
   endtask

   function automatic bit src_empty();
      bit r = 1'b1;
      for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) r = 1'b0;
      return r;
   endfunction

   task automatic wait_drain(input string name);
      bit done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         tick();
         done = src_empty() && exp_q.size() == 0 && grant_o == '0 && !out_valid_o;
      end
      chk(name, {63'd0, done}, 64'd1);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      for (int p = 0; p < NP; p++) src_q[p].delete();
      in_valid_i = '0; in_head_i = '0; in_tail_i = '0; in_flit_i = '0;
      credit_i = 1'b0; acc = '0; ov_d1 = 1'b0; ov_d2 = 1'b0; loop_en = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      exp_q.delete();
      pulse_q.delete();
      n_out = 0;
      rst_i = 1'b0;
   endtask

   initial begin
      // reset values
      do_reset();
      chk("rst_in_ready", 64'(in_ready_o), 64'd0);
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_out_flit", out_flit_o, 64'd0);
      chk("rst_out_tail", 64'(out_tail_o), 64'd0);
      chk("rst_grant", 64'(grant_o), 64'd0);
      chk("rst_credits", 64'(credits_o), 64'd4);
      chk("rst_credit_err", 64'(credit_err_o), 64'd0);

      // 3-flit packet on port 2 with credit loopback
      loop_en = 1'b1;
      send(2, 3, 64'hA0, 1);
      tick();
      chk("t1_grant_pre", 64'(grant_o), 64'd0);
      tick();
      chk("t1_grant", 64'(grant_o), 64'b0100);
      chk("t1_ready", 64'(in_ready_o), 64'b0100);
      tick(); tick(); tick();
      chk("t1_grant_released", 64'(grant_o), 64'd0);
      chk("t1_credits_mid", 64'(credits_o), 64'd1);
      wait_drain("t1_drain");
      chk("t1_pulses", 64'(pulse_q.size()), 64'd3);
      for (int i = 1; i < pulse_q.size(); i++)
         chk("t1_back_to_back", 64'(pulse_q[i] - pulse_q[i-1]), 64'd1);
      repeat (4) tick();
      chk("t1_credits_end", 64'(credits_o), 64'd4);

      // round robin among single-flit packets on ports 0,1,3
      do_reset();
      loop_en = 1'b1;
      send(0, 1, 64'h10, 0); send(0, 1, 64'h20, 0);
      send(1, 1, 64'h11, 0); send(1, 1, 64'h21, 0);
      send(3, 1, 64'h13, 0); send(3, 1, 64'h23, 0);
      push_exp1(64'h10, 1); push_exp1(64'h11, 1); push_exp1(64'h13, 1);
      push_exp1(64'h20, 1); push_exp1(64'h21, 1); push_exp1(64'h23, 1);
      wait_drain("t2_drain");
      chk("t2_pulses", 64'(pulse_q.size()), 64'd6);
      for (int i = 1; i < pulse_q.size(); i++)
         chk("t2_bubble", 64'(pulse_q[i] - pulse_q[i-1]), 64'd2);

      // credit starvation with a 6-flit packet
      do_reset();
      send(0, 6, 64'h30, 1);
      repeat (8) tick();
      chk("t3_ready_starved", 64'(in_ready_o), 64'd0);
      chk("t3_credits_zero", 64'(credits_o), 64'd0);
      chk("t3_flits_before", 64'(n_out), 64'd4);
      chk("t3_grant_held", 64'(grant_o), 64'b0001);
      tick_cr(1'b1);
      repeat (4) tick();
      chk("t3_flits_one_credit", 64'(n_out), 64'd5);
      chk("t3_ready_again_zero", 64'(in_ready_o), 64'd0);
      chk("t3_credits_zero2", 64'(credits_o), 64'd0);
      tick_cr(1'b1);
      repeat (3) tick();
      chk("t3_flits_all", 64'(n_out), 64'd6);
      wait_drain("t3_drain");

      // simultaneous credit and transfer, then overflow
      do_reset();
      send(1, 4, 64'h40, 1);
      tick(); tick(); tick();
      chk("t4_credits3", 64'(credits_o), 64'd3);
      tick_cr(1'b1);
      chk("t4_credits2", 64'(credits_o), 64'd2);
      chk("t4_ready", 64'(in_ready_o), 64'b0010);
      tick();
      chk("t4_credits_same", 64'(credits_o), 64'd2);
      tick(); tick();
      chk("t4_credits_after", 64'(credits_o), 64'd1);
      repeat (3) tick_cr(1'b1);
      tick();
      chk("t4_credits_full", 64'(credits_o), 64'd4);
      chk("t4_err_clear", 64'(credit_err_o), 64'd0);
      tick_cr(1'b1);
      tick();
      chk("t4_credits_sat", 64'(credits_o), 64'd4);
      chk("t4_err_set", 64'(credit_err_o), 64'd1);
      repeat (3) tick();
      chk("t4_err_sticky", 64'(credit_err_o), 64'd1);
      wait_drain("t4_drain");

      // asynchronous reset mid-packet
      do_reset();
      loop_en = 1'b1;
      send(0, 4, 64'h50, 0);
      push_exp1(64'h50, 0);
      tick(); tick(); tick();
      #2 rst_i = 1'b1;
      #1;
      chk("t5_out_valid", 64'(out_valid_o), 64'd0);
      chk("t5_out_flit", out_flit_o, 64'd0);
      chk("t5_grant", 64'(grant_o), 64'd0);
      chk("t5_ready", 64'(in_ready_o), 64'd0);
      chk("t5_credits", 64'(credits_o), 64'd4);
      chk("t5_flits_before", 64'(n_out), 64'd1);
      do_reset();
      loop_en = 1'b1;
      send(1, 1, 64'h5A, 1);
      tick(); tick();
      chk("t5_regrant", 64'(grant_o), 64'b0010);
      wait_drain("t5_drain");

`ifdef NI_INJ_ARB_STATS_EN
      // statistics: 10 packets with 7 starved cycles
      do_reset();
      send(2, 5, 64'h60, 1);
      tick();
      repeat (4) tick();
      repeat (6) tick();
      tick_cr(1'b1);
      tick(); tick();
      repeat (4) tick_cr(1'b1);
      tick();
      chk("t6_credits_restored", 64'(credits_o), 64'd4);
      loop_en = 1'b1;
      for (int k = 0; k < 9; k++) send(3, 1, 64'h70 + 64'(k), 1);
      wait_drain("t6_drain");
      chk("t6_pkt_count", 64'(pkt_count_o), 64'd10);
      chk("t6_stall_cycles", 64'(stall_cycles_o), 64'd7);
`endif

      chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
